// File: rtl/vga_timing_params.sv
// Shared timing constants for the 1280x1024@60 VGA timing generator and
// the small helpers used to derive line/frame totals and sync windows.
package vga_timing_params;

    localparam int CNT_W = 11;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_FP_DEF     = 48;
    localparam int H_SYNC_DEF   = 112;
    localparam int H_BP_DEF     = 248;

    localparam int V_ACTIVE_DEF = 1024;
    localparam int V_FP_DEF     = 1;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 38;

    localparam int RGB_LATENCY_DEF = 2;

    // Bit order matters: this bundle travels through delay_line as a 3-bit word.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic valid;
    } sync_t;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int hi);
        return (int'(cnt) >= lo) && (int'(cnt) < hi);
    endfunction

endpackage

// File: rtl/delay_line.sv
// WIDTH x DEPTH shift register with synchronous active-low clear; also exposes
// the word about to enter the last stage so callers can pre-register against it.
module delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_next
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_single
            assign dout_next = din;
        end else begin : g_multi
            assign dout_next = stage[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counter with zero-latency coordinates for the pixel
// source and RGB_LATENCY-delayed syncs/blank/colour for the output pins.
module vga_timing_gen
    import vga_timing_params::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int RGB_LATENCY = RGB_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        valid,
    output logic        vsync,
    output logic        frame_start,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int H_LINE  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_FRAME = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_LINE - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_FRAME - 1);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    sync_t cur_sync;
    sync_t dly_sync;
    sync_t dly_next;

    // Reset parks the counters on the last pixel so the first released edge lands on (0,0).
    always_ff @(posedge clk) begin
        if (!reset) begin
            h <= H_LAST;
            v <= V_LAST;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 11'd1;
        end else begin
            h <= h + 11'd1;
        end
    end

    always_comb begin
        cur_sync.valid = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
        cur_sync.hsync = in_window(h, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
        cur_sync.vsync = in_window(v, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    end

    assign x           = h;
    assign y           = v[9:0];
    assign valid       = cur_sync.valid;
    assign vsync       = cur_sync.vsync;
    assign frame_start = (h == '0) && (v == '0);

    delay_line #(
        .WIDTH (3),
        .DEPTH (RGB_LATENCY)
    ) u_sync_delay (
        .clk       (clk),
        .reset     (reset),
        .din       (cur_sync),
        .dout      (dly_sync),
        .dout_next (dly_next)
    );

    assign vga_hsync   = dly_sync.hsync;
    assign vga_vsync   = dly_sync.vsync;
    assign vga_blank_n = dly_sync.valid;

    // Gating on the valid entering the last stage keeps colour and blank_n in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (dly_next.valid) begin
            vga_r <= r;
            vga_g <= g;
            vga_b <= b;
        end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster so whole frames fit
// in a short run; expected values come from raster arithmetic on a pixel index.
module tb_vga_timing_gen;

    localparam int HA = 64;
    localparam int HF = 8;
    localparam int HS = 12;
    localparam int HB = 16;
    localparam int VA = 20;
    localparam int VF = 2;
    localparam int VS = 3;
    localparam int VB = 5;
    localparam int L  = 3;

    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    localparam int TX = 30;
    localparam int TY = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        vsync;
    logic        frame_start;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE    (HA),
        .H_FP        (HF),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .V_ACTIVE    (VA),
        .V_FP        (VF),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .RGB_LATENCY (L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .valid       (valid),
        .vsync       (vsync),
        .frame_start (frame_start),
        .r           (r),
        .g           (g),
        .b           (b),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    typedef struct {
        logic [10:0] ex;
        logic [9:0]  ey;
        logic        evalid;
        logic        evsync;
        logic        efs;
        logic        ehs;
        logic        evs;
        logic        ebn;
        logic [7:0]  er;
        logic [7:0]  eg;
        logic [7:0]  eb;
        int          k;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int k      = 0;
    int cur_x  = 0;
    int cur_y  = 0;
    int cyc    = 0;
    int last_fs = 0;
    bit fs_armed = 1'b0;
    logic [7:0] pr = 8'h00;
    logic [7:0] pg = 8'h00;
    logic [7:0] pb = 8'h00;

    // Raster position after the j-th released edge; j<=0 is the parked reset position.
    task automatic pix(input int j, output int px, output int py,
                       output logic pv, output logic phs, output logic pvs, output logic pfs);
        int p;
        if (j <= 0) begin
            px  = HT - 1;
            py  = VT - 1;
            pfs = 1'b0;
        end else begin
            p   = (j - 1) % FRAME;
            px  = p % HT;
            py  = p / HT;
            pfs = (p == 0);
        end
        pv  = (px < HA) && (py < VA);
        phs = (px >= HA + HF) && (px < HA + HF + HS);
        pvs = (py >= VA + VF) && (py < VA + VF + VS);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d (k=%0d)", name, act, exp, cyc, mon_e.k);
        end
    endtask

    // One clock: advance the model, queue what the DUT must show, then drive the next colour.
    task automatic applyStimulus();
        exp_t e;
        int px, py, dx, dy, sx, sy;
        logic pv, phs, pvs, pfs, dv, dhs, dvs, dfs, sv, shs, svs, sfs;
        @(posedge clk);
        #1;
        k = reset ? k + 1 : 0;
        pix(k, px, py, pv, phs, pvs, pfs);
        cur_x = px;
        cur_y = py;
        e.ex     = 11'(px);
        e.ey     = 10'(py);
        e.evalid = pv;
        e.evsync = pvs;
        e.efs    = pfs;
        pix(k - L, dx, dy, dv, dhs, dvs, dfs);
        e.ehs = dhs;
        e.evs = dvs;
        e.ebn = dv;
        e.er  = dv ? pr : 8'h00;
        e.eg  = dv ? pg : 8'h00;
        e.eb  = dv ? pb : 8'h00;
        e.k   = k;
        sb.push_back(e);
        pix(k + 1 - L, sx, sy, sv, shs, svs, sfs);
        r = 8'($urandom);
        g = 8'($urandom);
        b = 8'($urandom);
        if (k + 1 - L >= 1 && sx == 0 && sy == 0) begin
            r = 8'hAA;
        end else if (!sv && $urandom_range(0, 1) == 1) begin
            r = 8'hFF;
        end
        pr = r;
        pg = g;
        pb = b;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput("x",           32'(x),           32'(mon_e.ex));
            checkOutput("y",           32'(y),           32'(mon_e.ey));
            checkOutput("valid",       32'(valid),       32'(mon_e.evalid));
            checkOutput("vsync",       32'(vsync),       32'(mon_e.evsync));
            checkOutput("frame_start", 32'(frame_start), 32'(mon_e.efs));
            checkOutput("vga_hsync",   32'(vga_hsync),   32'(mon_e.ehs));
            checkOutput("vga_vsync",   32'(vga_vsync),   32'(mon_e.evs));
            checkOutput("vga_blank_n", 32'(vga_blank_n), 32'(mon_e.ebn));
            checkOutput("vga_r",       32'(vga_r),       32'(mon_e.er));
            checkOutput("vga_g",       32'(vga_g),       32'(mon_e.eg));
            checkOutput("vga_b",       32'(vga_b),       32'(mon_e.eb));
            if (mon_e.k == 0) begin
                fs_armed = 1'b0;
            end else if (frame_start === 1'b1) begin
                if (fs_armed) begin
                    checkOutput("frame_period", 32'(cyc - last_fs), 32'(FRAME));
                end
                last_fs  = cyc;
                fs_armed = 1'b1;
            end
        end
    end

    initial begin
        int n;
        reset = 1'b0;
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        $display("[TB] raster %0dx%0d, latency %0d", HT, VT, L);

        repeat (5) applyStimulus();
        reset = 1'b1;
        repeat (2 * FRAME + 50) applyStimulus();

        n = 0;
        while (!(cur_x == TX && cur_y == TY) && n < FRAME + 1) begin
            applyStimulus();
            n++;
        end
        reset = 1'b0;
        applyStimulus();
        reset = 1'b1;
        repeat (FRAME / 2) applyStimulus();

        repeat (4000) begin
            applyStimulus();
            reset = ($urandom_range(0, 499) != 0);
        end
        reset = 1'b1;
        repeat (L + 2) applyStimulus();

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 48: horizontal front porch, in clocks.
REQ-003 SHALL have parameter H_SYNC, default 112: hsync width, in clocks.
REQ-004 SHALL have parameter H_BP, default 248: horizontal back porch; H_TOTAL = 1688.
REQ-005 SHALL have parameters V_ACTIVE 1024, V_FP 1, V_SYNC 3, V_BP 38, all in lines; V_TOTAL = 1066.
REQ-006 SHALL have parameter RGB_LATENCY, default 2, legal range 1..4: pixel-pipeline depth of the downstream pixel source.
REQ-007 SHALL have port clk, input, 1 bit: single pixel clock (108 MHz); all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-low; reset==0 resets the block.
REQ-009 SHALL have port x, output, 11 bits: current horizontal count.
REQ-010 SHALL have port y, output, 10 bits: low 10 bits of the current vertical count.
REQ-011 SHALL have port valid, output, 1 bit: the current (x,y) is in the active area.
REQ-012 SHALL have port vsync, output, 1 bit: undelayed vertical sync, used as the idle indicator by the pixel source.
REQ-013 SHALL have port frame_start, output, 1 bit: one-clock pulse at pixel (0,0).
REQ-014 SHALL have ports r, g, b, inputs, 8 bits each: pixel colour from the source, arriving RGB_LATENCY-1 clocks after its (x,y).
REQ-015 SHALL have ports vga_hsync and vga_vsync, outputs, 1 bit each: delayed syncs, positive polarity.
REQ-016 SHALL have port vga_blank_n, output, 1 bit: delayed valid.
REQ-017 SHALL have ports vga_r, vga_g, vga_b, outputs, 8 bits each: registered colour driven to the pins.

Function
REQ-018 SHALL keep 11-bit counters h and v; each clock, h increments, and when h==H_TOTAL-1 it wraps to 0.
REQ-019 SHALL increment v when h wraps, and when v==V_TOTAL-1 at the same wrap, wrap v to 0.
REQ-020 SHALL drive x=h and y=v[9:0] combinationally from the counter registers.
REQ-021 SHALL assert valid iff h<H_ACTIVE and v<V_ACTIVE.
REQ-022 SHALL assert vsync iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (v 1025..1027 by default).
REQ-023 SHALL assert the internal hsync iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (h 1328..1439 by default).
REQ-024 SHALL assert frame_start iff h==0 and v==0.
REQ-025 SHALL delay hsync, vsync and valid by exactly RGB_LATENCY registered stages to form vga_hsync, vga_vsync and vga_blank_n.
REQ-026 SHALL register r, g, b once into vga_r, vga_g, vga_b, so a pixel's colour appears in the same cycle as its vga_blank_n.
REQ-027 SHALL force vga_r, vga_g and vga_b to 0 in any cycle where that same-cycle delayed valid is 0, regardless of the r, g, b inputs.
REQ-028 SHALL keep the timing free-running with no stall input; x, y, valid, vsync and frame_start have zero latency relative to the counters.

Reset
REQ-029 SHALL, while reset==0, load h=H_TOTAL-1 and v=V_TOTAL-1, so x=1687, y=41, and valid, vsync, hsync and frame_start are all 0.
REQ-030 SHALL, while reset==0, clear every delay stage and colour register, so vga_hsync=0, vga_vsync=0, vga_blank_n=0 and vga_r/g/b=0.
REQ-031 SHALL make the first clock edge with reset==1 produce x=0, y=0, valid=1 and frame_start=1.
REQ-032 SHALL treat reset asserted mid-frame as overriding counting on that edge, with no partial-line completion.

Structure
REQ-033 SHALL take the default timing constants and the derived H_TOTAL and V_TOTAL from a shared package, vga_timing_params.
REQ-034 SHALL implement the sync and blank alignment with one sub-module, delay_line, a parameterized WIDTH x DEPTH shift register with synchronous active-low clear, instantiated once with WIDTH=3 and DEPTH=RGB_LATENCY.

Verification
REQ-035 SHALL verify post-reset start: hold reset=0 for 5 clocks, then release -> the first edge gives x=0, y=0, valid=1, frame_start=1, and all vga_* outputs are 0 for RGB_LATENCY clocks.
REQ-036 SHALL verify line wrap: at x=1687, y=5 -> the next clock gives x=0, y=6, and valid stays 0 from x=1280 through x=1687.
REQ-037 SHALL verify sync positions: hsync is high for exactly 112 clocks starting at x=1328, and vsync is high exactly for lines 1025..1027 (3 x 1688 clocks).
REQ-038 SHALL verify frame period: frame_start pulses exactly 1688 x 1066 = 1,799,408 clocks apart.
REQ-039 SHALL verify colour alignment and blanking: drive r=8'hAA only for the pixel source's (x=0,y=0) output -> vga_r=8'hAA coincides with the first vga_blank_n=1 cycle; drive r=8'hFF during blanking -> vga_r=0.
REQ-040 SHALL verify reset mid-frame: assert reset at x=600, y=300 for 1 clock -> the next post-reset edge gives x=0, y=0, and the delayed syncs are cleared.
